// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encodings and response kinds for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_W  = 36;
  localparam int PADDR_W = 22;
  localparam int TMO_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    RESP_READ,
    RESP_WRITE,
    RESP_NXM
  } resp_kind_t;

endpackage

// File: rtl/mem_timeout.sv
// Counts cycles spent waiting on memory; expired fires on the cycle whose edge
// would bring the count up to TIMEOUT.
module mem_timeout
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two requesters a single outstanding memory
// transaction, with timeout-generated non-existent-memory responses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_read,
  input  logic               req0_write,
  input  logic [PADDR_W-1:0] req0_addr,
  input  logic [WORD_W-1:0]  req0_wdata,
  output logic [WORD_W-1:0]  req0_rdata,
  output logic               req0_read_ack,
  output logic               req0_write_ack,
  output logic               req0_nxm,
  input  logic               req1_read,
  input  logic               req1_write,
  input  logic [PADDR_W-1:0] req1_addr,
  input  logic [WORD_W-1:0]  req1_wdata,
  output logic [WORD_W-1:0]  req1_rdata,
  output logic               req1_read_ack,
  output logic               req1_write_ack,
  output logic               req1_nxm,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [WORD_W-1:0]  mem_read_data,
  input  logic               read_ack,
  input  logic               write_ack,
  input  logic               nxm
);

  arb_state_t         state, next_state;
  resp_kind_t         resp_kind;
  logic               any0, any1;
  logic               grant_sel, sel_read;
  logic [PADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0]  sel_wdata;
  logic               last_grant, cur_grant, cur_read;
  logic               good_ack, expired, issue, finish;
  logic               deliver0, deliver1;

  assign any0     = req0_read | req0_write;
  assign any1     = req1_read | req1_write;
  // An acknowledge of the wrong kind is not a completion; only the timeout can rescue it.
  assign good_ack = cur_read ? read_ack : write_ack;

  mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_BUSY),
    .enable (state == ST_BUSY),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (any0 || any1) next_state = ST_BUSY;
      ST_BUSY: if (nxm || good_ack || expired) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    issue     = (state == ST_IDLE) && (any0 || any1);
    finish    = (state == ST_BUSY) && (nxm || good_ack || expired);
    grant_sel = (any0 && any1) ? ~last_grant : any1;
    sel_read  = grant_sel ? req1_read  : req0_read;
    sel_addr  = grant_sel ? req1_addr  : req0_addr;
    sel_wdata = grant_sel ? req1_wdata : req0_wdata;
    resp_kind = RESP_NXM;
    if (!nxm && good_ack) resp_kind = cur_read ? RESP_READ : RESP_WRITE;
    deliver0  = finish && !cur_grant;
    deliver1  = finish &&  cur_grant;
  end

  // Requester-facing outputs are rebuilt every cycle, so anything not being
  // delivered this cycle falls back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cur_grant      <= 1'b0;
      cur_read       <= 1'b0;
      last_grant     <= 1'b1;
      req0_read_ack  <= 1'b0;
      req0_write_ack <= 1'b0;
      req0_nxm       <= 1'b0;
      req0_rdata     <= '0;
      req1_read_ack  <= 1'b0;
      req1_write_ack <= 1'b0;
      req1_nxm       <= 1'b0;
      req1_rdata     <= '0;
    end else begin
      mem_read  <= issue &&  sel_read;
      mem_write <= issue && !sel_read;
      if (issue) begin
        mem_addr       <= sel_addr;
        mem_write_data <= sel_wdata;
        cur_grant      <= grant_sel;
        cur_read       <= sel_read;
        last_grant     <= grant_sel;
      end
      req0_read_ack  <= deliver0 && (resp_kind == RESP_READ);
      req0_write_ack <= deliver0 && (resp_kind == RESP_WRITE);
      req0_nxm       <= deliver0 && (resp_kind == RESP_NXM);
      req0_rdata     <= (deliver0 && (resp_kind == RESP_READ)) ? mem_read_data : '0;
      req1_read_ack  <= deliver1 && (resp_kind == RESP_READ);
      req1_write_ack <= deliver1 && (resp_kind == RESP_WRITE);
      req1_nxm       <= deliver1 && (resp_kind == RESP_NXM);
      req1_rdata     <= (deliver1 && (resp_kind == RESP_READ)) ? mem_read_data : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency memory model
// whose acknowledges can be switched off and injected by hand.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TIMEOUT = 15;
  localparam logic [PADDR_W-1:0] ADDR_RD  = 'o1000;
  localparam logic [PADDR_W-1:0] ADDR_WA  = 'o2000;
  localparam logic [PADDR_W-1:0] ADDR_WB  = 'o2001;
  localparam logic [PADDR_W-1:0] ADDR_R0  = 'o100;
  localparam logic [PADDR_W-1:0] ADDR_R1  = 'o200;
  localparam logic [PADDR_W-1:0] ADDR_NXM = 'o300;
  localparam logic [WORD_W-1:0]  VAL_RD   = 36'o123456701234;
  localparam logic [WORD_W-1:0]  VAL_R0   = 36'o111111111111;
  localparam logic [WORD_W-1:0]  VAL_R1   = 36'o222222222222;
  localparam logic [WORD_W-1:0]  VAL_WA   = 36'o707070707070;
  localparam logic [WORD_W-1:0]  VAL_WB   = 36'o012345670123;

  logic clk = 1'b0;
  logic reset;
  logic req0_read, req0_write, req1_read, req1_write;
  logic [PADDR_W-1:0] req0_addr, req1_addr, mem_addr;
  logic [WORD_W-1:0]  req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic [WORD_W-1:0]  mem_write_data, mem_read_data;
  logic req0_read_ack, req0_write_ack, req0_nxm;
  logic req1_read_ack, req1_write_ack, req1_nxm;
  logic mem_read, mem_write, read_ack, write_ack, nxm;

  logic memAuto, injReadAck, injWriteAck, injNxm;
  logic autoReadAck, autoWriteAck;
  logic preloadEn;
  logic [11:0] preloadAddr;
  logic [WORD_W-1:0] preloadData, rdData;
  logic [WORD_W-1:0] ram [0:4095];
  logic [PADDR_W-1:0] grantLog [$];
  int rdStrobes = 0;
  int wrStrobes = 0;

  int compareCount = 0;
  int mismatchCount = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_read_ack(req0_read_ack),
    .req0_write_ack(req0_write_ack), .req0_nxm(req0_nxm),
    .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_read_ack(req1_read_ack),
    .req1_write_ack(req1_write_ack), .req1_nxm(req1_nxm),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_read_data(mem_read_data), .read_ack(read_ack),
    .write_ack(write_ack), .nxm(nxm)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after a strobe when memAuto is set.
  always @(posedge clk) begin
    autoReadAck  <= memAuto && mem_read;
    autoWriteAck <= memAuto && mem_write;
    if (mem_read) begin
      rdData    <= ram[mem_addr[11:0]];
      rdStrobes <= rdStrobes + 1;
      grantLog.push_back(mem_addr);
    end
    if (mem_write) begin
      ram[mem_addr[11:0]] <= mem_write_data;
      wrStrobes <= wrStrobes + 1;
      grantLog.push_back(mem_addr);
    end
    if (preloadEn) ram[preloadAddr] <= preloadData;
  end

  assign mem_read_data = rdData;
  assign read_ack  = autoReadAck  | injReadAck;
  assign write_ack = autoWriteAck | injWriteAck;
  assign nxm       = injNxm;

  function automatic logic [2:0] acks0();
    return {req0_read_ack, req0_write_ack, req0_nxm};
  endfunction

  function automatic logic [2:0] acks1();
    return {req1_read_ack, req1_write_ack, req1_nxm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r0r, input logic r0w, input logic [PADDR_W-1:0] a0,
                               input logic [WORD_W-1:0] d0, input logic r1r, input logic r1w,
                               input logic [PADDR_W-1:0] a1, input logic [WORD_W-1:0] d1);
    req0_read = r0r; req0_write = r0w; req0_addr = a0; req0_wdata = d0;
    req1_read = r1r; req1_write = r1w; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idleRequests();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input logic [11:0] addr, input logic [WORD_W-1:0] data);
    preloadEn = 1'b1; preloadAddr = addr; preloadData = data;
    tick();
    preloadEn = 1'b0;
  endtask

  task automatic applyReset(input string tag);
    reset = 1'b0;
    idleRequests();
    tick();
    tick();
    checkOutput({tag, "_strobes_acks"},
                {mem_read, mem_write, acks0(), acks1()}, 64'd0);
    checkOutput({tag, "_mem_addr_data"}, {mem_addr, mem_write_data}, 64'd0);
    checkOutput({tag, "_rdata"}, {req0_rdata, req1_rdata}, 64'd0);
    reset = 1'b1;
    tick();
  endtask

  task automatic waitAck(input int who, input int maxCycles, output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < maxCycles) begin
      tick();
      cycles++;
      seen = (who == 0) ? (acks0() != 3'b000) : (acks1() != 3'b000);
    end
    if (!seen) cycles = -1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, rdBase, wrBase, base, done, seq0, seq1;
    logic [2:0] accum;

    reset = 1'b0;
    memAuto = 1'b1; injReadAck = 1'b0; injWriteAck = 1'b0; injNxm = 1'b0;
    preloadEn = 1'b0; preloadAddr = '0; preloadData = '0;
    idleRequests();
    tick();
    preload(ADDR_RD[11:0], VAL_RD);
    preload(ADDR_R0[11:0], VAL_R0);
    preload(ADDR_R1[11:0], VAL_R1);
    applyReset("rst0");

    // Zero-wait read from requester 0
    rdBase = rdStrobes;
    applyStimulus(1'b1, 1'b0, ADDR_RD, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("rd_strobe", {mem_read, mem_write}, 2'b10);
    checkOutput("rd_addr", mem_addr, ADDR_RD);
    waitAck(0, 20, cyc);
    checkOutput("rd_latency", cyc, 2);
    checkOutput("rd_ack", acks0(), 3'b100);
    checkOutput("rd_data", req0_rdata, VAL_RD);
    checkOutput("rd_other_quiet", {acks1(), req1_rdata}, 0);
    idleRequests();
    tick();
    checkOutput("rd_ack_one_cycle", acks0(), 3'b000);
    tick();
    checkOutput("rd_no_regrant", rdStrobes - rdBase, 1);

    // Simultaneous writes right after reset: requester 0 wins the tie
    applyReset("rst1");
    wrBase = wrStrobes;
    applyStimulus(1'b0, 1'b1, ADDR_WA, VAL_WA, 1'b0, 1'b1, ADDR_WB, VAL_WB);
    tick();
    checkOutput("wr_first_strobe", {mem_read, mem_write}, 2'b01);
    checkOutput("wr_first_addr", mem_addr, ADDR_WA);
    checkOutput("wr_first_data", mem_write_data, VAL_WA);
    waitAck(0, 20, cyc);
    checkOutput("wr0_ack", acks0(), 3'b010);
    checkOutput("wr0_other_quiet", acks1(), 3'b000);
    req0_write = 1'b0;
    waitAck(1, 20, cyc);
    checkOutput("wr1_ack", acks1(), 3'b010);
    req1_write = 1'b0;
    tick();
    checkOutput("wr_ram_a", ram[ADDR_WA[11:0]], VAL_WA);
    checkOutput("wr_ram_b", ram[ADDR_WB[11:0]], VAL_WB);
    checkOutput("wr_strobe_count", wrStrobes - wrBase, 2);

    // Both requesters reading continuously: grants must alternate
    base = grantLog.size();
    done = 0;
    applyStimulus(1'b1, 1'b0, ADDR_R0, '0, 1'b1, 1'b0, ADDR_R1, '0);
    for (int i = 0; i < 200 && done < 8; i++) begin
      tick();
      if (req0_read_ack) begin
        checkOutput("rr_data0", req0_rdata, VAL_R0);
        done++;
      end
      if (req1_read_ack) begin
        checkOutput("rr_data1", req1_rdata, VAL_R1);
        done++;
      end
    end
    idleRequests();
    tick();
    tick();
    checkOutput("rr_completions", done, 8);
    checkOutput("rr_grant_count", grantLog.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < grantLog.size())
        checkOutput($sformatf("rr_grant%0d", i), grantLog[base + i],
                    (i % 2 == 0) ? ADDR_R0 : ADDR_R1);
    end

    // Memory never answers: timeout produces nxm to requester 1
    memAuto = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, ADDR_NXM, '0);
    tick();
    checkOutput("tmo_strobe", mem_read, 1'b1);
    waitAck(1, 40, cyc);
    checkOutput("tmo_cycles", cyc, TIMEOUT);
    checkOutput("tmo_nxm", acks1(), 3'b001);
    checkOutput("tmo_rdata", req1_rdata, 0);
    idleRequests();
    tick();
    memAuto = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, ADDR_RD, '0);
    tick();
    waitAck(1, 20, cyc);
    checkOutput("tmo_next_ack", acks1(), 3'b100);
    checkOutput("tmo_next_data", req1_rdata, VAL_RD);
    idleRequests();
    tick();

    // nxm together with read_ack gives nxm
    memAuto = 1'b0;
    applyStimulus(1'b1, 1'b0, ADDR_RD, '0, 1'b0, 1'b0, '0, '0);
    tick();
    injReadAck = 1'b1; injNxm = 1'b1;
    tick();
    injReadAck = 1'b0; injNxm = 1'b0;
    checkOutput("nxm_wins", acks0(), 3'b001);
    checkOutput("nxm_rdata", req0_rdata, 0);
    idleRequests();
    tick();

    // Spurious read_ack in IDLE, wrong-kind write_ack during a read
    rdBase = rdStrobes;
    injReadAck = 1'b1;
    tick();
    injReadAck = 1'b0;
    tick();
    checkOutput("spur_idle", {mem_read, mem_write, acks0(), acks1()}, 0);
    applyStimulus(1'b1, 1'b0, ADDR_RD, '0, 1'b0, 1'b0, '0, '0);
    tick();
    injWriteAck = 1'b1;
    tick();
    injWriteAck = 1'b0;
    checkOutput("spur_wack_ignored", acks0(), 3'b000);
    tick();
    checkOutput("spur_still_busy", acks0(), 3'b000);
    injReadAck = 1'b1;
    tick();
    injReadAck = 1'b0;
    checkOutput("spur_real_ack", acks0(), 3'b100);
    checkOutput("spur_data", req0_rdata, VAL_RD);
    idleRequests();
    tick();
    checkOutput("spur_one_strobe", rdStrobes - rdBase, 1);

    // Reset in BUSY abandons the transaction silently
    applyStimulus(1'b1, 1'b0, ADDR_RD, '0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    applyReset("rst_busy");
    accum = 3'b000;
    seq0 = 0;
    seq1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      accum = accum | acks0() | acks1();
      seq0 = seq0 + int'(mem_read);
    end
    checkOutput("rst_no_pulse", {accum, seq0[3:0]}, 0);
    memAuto = 1'b1;
    applyStimulus(1'b1, 1'b0, ADDR_R0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    waitAck(0, 20, cyc);
    checkOutput("rst_after_latency", cyc, 2);
    checkOutput("rst_after_data", req0_rdata, VAL_R0);
    idleRequests();
    tick();
    seq1 = seq1 + 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
